lsu_unit: RTL and testbench
===========================

Name: lsu_unit

Overview:
- Load/store unit directly downstream of the ALU.
- Takes the ALU result as the effective address and RS2 as store data, and runs a valid/ready transaction to data memory.
- Returns size-extended load data to the ALU/MEM writeback select.
- Asserts busy so the control unit can hold PC and register writeback until the access completes.

Parameters:
- XLEN, 64, data width of registers and memory bus.
- NBYTES, 8, bytes per memory word (XLEN/8); width of the write strobe.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  load/store request from control unit; held until accepted
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 giving size and signedness
- req_addr  in  XLEN  effective address (ALU result)
- req_wdata  in  XLEN  store data (RS2)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores
- resp_err  out  1  misaligned or illegal funct3; qualified by resp_valid
- busy  out  1  transaction in progress
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  XLEN  req_addr with bits [2:0] cleared
- mem_we  out  1  write enable
- mem_wdata  out  XLEN  lane-aligned store data
- mem_wstrb  out  NBYTES  byte enables
- mem_resp_valid  in  1  read data ready / write acknowledged
- mem_rdata  in  XLEN  read word

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0 except req_ready, which is 1.
  - resp_rdata is cleared to 0.
- State machine: IDLE -> REQ -> WAIT -> RESP -> IDLE, plus IDLE -> RESP on error.
- IDLE:
  - req_ready=1, busy=0.
  - On req_valid, capture we, funct3, addr, wdata.
  - If an error is detected, go to RESP with err=1 and issue no memory access. Otherwise go to REQ.
- Error detection:
  - Illegal: load funct3 = 111; store funct3[2] = 1.
  - Misaligned: H with addr[0] != 0; W with addr[1:0] != 0; D with addr[2:0] != 0.
- REQ:
  - mem_req_valid=1.
  - mem_addr, mem_we, mem_wdata and mem_wstrb come from capture registers and stay stable until mem_req_ready.
  - On mem_req_ready, go to WAIT.
  - mem_resp_valid in REQ is ignored.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid, go to RESP.
  - For loads, register the extended data into resp_rdata. For stores, set resp_rdata to 0.
- RESP:
  - resp_valid=1 for exactly one cycle, then go to IDLE.
  - resp_rdata and resp_err hold their values until the next RESP.
- Outputs by state:
  - busy = (state != IDLE); req_ready = (state == IDLE).
  - A new request can be accepted the cycle after RESP.
- Latency: request accepted at cycle T, mem_req_valid at T+1. If memory is ready and responds at once, resp_valid is at T+3. Each back-pressure or response-wait cycle adds one cycle.
- Size from funct3[1:0]: 00 B (1 byte), 01 H (2), 10 W (4), 11 D (8). funct3[2]=1 means zero-extend (LBU/LHU/LWU).
- Store lane:
  - off = addr[2:0].
  - mem_wstrb = ((1<<size_bytes)-1) << off, truncated to NBYTES.
  - mem_wdata = req_wdata << (8*off); unused lanes are don't-care but driven deterministically.
- Load extract:
  - raw = mem_rdata >> (8*off), masked to size.
  - Sign-extend from the top bit of size when funct3[2]=0; zero-extend otherwise.
  - LD returns the word unmodified.
- Loads drive mem_wstrb=0 and mem_we=0.
- Reset mid-operation:
  - An abort in REQ or WAIT drops the transaction with no resp_valid.
  - A late mem_resp_valid arriving in IDLE is ignored.
- req_valid while busy is ignored; the requester holds it until req_ready.

Test Plan:
- LD addr 0x80000010, mem_rdata 0x1122334455667788, immediate ready/resp -> mem_addr 0x80000010, wstrb 0x00, resp_valid at T+3, rdata 0x1122334455667788, err 0.
- LB addr 0x80000003, mem_rdata 0x0000000080000000 -> rdata 0xFFFFFFFFFFFFFF80. LBU with the same stimulus -> 0x0000000000000080.
- SH addr 0x80000006, wdata 0xABCD -> mem_wstrb 0xC0, mem_wdata[63:48]=0xABCD, mem_we 1. After mem_resp_valid -> resp_valid, rdata 0, err 0.
- LW addr 0x80000002, and load funct3=111 -> each gives resp_valid at T+1 with err 1; mem_req_valid never asserts.
- SD with mem_req_ready low for 3 cycles -> mem_req_valid/addr/wdata/wstrb(0xFF) stable for all 4 cycles, busy=1, req_ready=0. Second req_valid during this is not accepted.
- rst low during WAIT -> busy 0, req_ready 1, all outputs 0 immediately. A following mem_resp_valid yields no resp_valid. A new LD then completes normally.

Source files
------------

// File: rtl/lsu_unit.sv
// Load/store unit sitting behind the ALU. It takes the ALU result as the
// effective address and RS2 as store data, and runs one valid/ready access
// to data memory. It returns size-extended load data and holds busy while
// an access is in flight. Misaligned or illegal requests skip memory and
// complete with resp_err set.
module lsu_unit #(
    parameter int XLEN   = 64,
    parameter int NBYTES = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [NBYTES-1:0] mem_wstrb,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic              cap_we;
    logic [2:0]        cap_funct3;
    logic [XLEN-1:0]   cap_addr;
    logic [XLEN-1:0]   cap_wdata;
    logic              req_err;
    logic              accept;
    logic [2:0]        off;
    int                size_bytes;
    logic [NBYTES-1:0] lane_strb;
    logic [XLEN-1:0]   load_shift;
    logic [XLEN-1:0]   load_ext;
    logic              sx;

    assign accept = (state == IDLE) && req_valid;

    // Classify the incoming request as illegal or misaligned.
    always_comb begin
        req_err = 1'b0;
        if (req_we) begin
            if (req_funct3[2]) req_err = 1'b1;
        end else if (req_funct3 == 3'b111) begin
            req_err = 1'b1;
        end
        case (req_funct3[1:0])
            2'b01:   if (req_addr[0])        req_err = 1'b1;
            2'b10:   if (|req_addr[1:0])     req_err = 1'b1;
            2'b11:   if (|req_addr[2:0])     req_err = 1'b1;
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; errors go straight to RESP without touching memory.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = req_err ? RESP : REQ;
            REQ:  if (mem_req_ready) state_nxt = WAIT;
            WAIT: if (mem_resp_valid) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        req_ready     = 1'b0;
        busy          = 1'b1;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        case (state)
            IDLE: begin req_ready = 1'b1; busy = 1'b0; end
            REQ:  mem_req_valid = 1'b1;
            RESP: resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Latch the request on acceptance; memory-side fields hold from here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_we     <= 1'b0;
            cap_funct3 <= 3'b000;
            cap_addr   <= '0;
            cap_wdata  <= '0;
        end else if (accept) begin
            cap_we     <= req_we;
            cap_funct3 <= req_funct3;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
        end
    end

    // Byte lane placement for stores and lane extraction for loads.
    always_comb begin
        off        = cap_addr[2:0];
        size_bytes = 1 << cap_funct3[1:0];
        sx         = ~cap_funct3[2];
        for (int i = 0; i < NBYTES; i++)
            lane_strb[i] = (i >= int'(off)) && (i < int'(off) + size_bytes);
        load_shift = mem_rdata >> {off, 3'b000};
        case (cap_funct3[1:0])
            2'b00:   load_ext = {{(XLEN-8){sx & load_shift[7]}},   load_shift[7:0]};
            2'b01:   load_ext = {{(XLEN-16){sx & load_shift[15]}}, load_shift[15:0]};
            2'b10:   load_ext = {{(XLEN-32){sx & load_shift[31]}}, load_shift[31:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    assign mem_addr  = {cap_addr[XLEN-1:3], 3'b000};
    assign mem_we    = cap_we;
    assign mem_wdata = cap_wdata << {off, 3'b000};
    assign mem_wstrb = cap_we ? lane_strb : '0;

    // Response registers change only on entry to RESP and hold afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept && req_err) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
        end else if (state == WAIT && mem_resp_valid) begin
            resp_rdata <= cap_we ? '0 : load_ext;
            resp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: loads, stores, error paths, memory
// back-pressure and mid-transaction reset, against hand-computed values.
module tb_lsu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, busy;
    logic [63:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wstrb;

    int checks = 0;
    int errors = 0;

    // Observed during the last do_req call.
    logic [63:0] m_addr, m_wdata, r_rdata;
    logic [7:0]  m_wstrb;
    logic        m_we, saw_mem, r_err;
    int          lat;

    always #5 clk = ~clk;

    lsu_unit #(.XLEN(64), .NBYTES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Present one request for one cycle (caller is just after a posedge with
    // the unit idle), then follow it until resp_valid. lat counts cycles
    // after acceptance; returns at the negedge of the RESP cycle.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata;
        saw_mem = 1'b0; lat = 0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            lat++;
            @(negedge clk);
            if (mem_req_valid) begin
                saw_mem = 1'b1;
                m_addr = mem_addr; m_wdata = mem_wdata;
                m_wstrb = mem_wstrb; m_we = mem_we;
            end
            if (resp_valid) begin
                r_rdata = resp_rdata; r_err = resp_err;
                break;
            end
            if (i == 19) check("resp_timeout", {63'd0, resp_valid}, 64'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        mem_rdata = 64'h1122334455667788;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_wstrb", {56'd0, mem_wstrb}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_err", {63'd0, resp_err}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // LD, immediate memory
        do_req(1'b0, 3'b011, 64'h80000010, 64'd0);
        check("ld_lat", 64'(lat), 64'd3);
        check("ld_addr", m_addr, 64'h80000010);
        check("ld_wstrb", {56'd0, m_wstrb}, 64'd0);
        check("ld_we", {63'd0, m_we}, 64'd0);
        check("ld_rdata", r_rdata, 64'h1122334455667788);
        check("ld_err", {63'd0, r_err}, 64'd0);
        @(posedge clk); #1;
        check("ld_resp_pulse", {63'd0, resp_valid}, 64'd0);
        check("ld_ready_after", {63'd0, req_ready}, 64'd1);

        // LB / LBU on a 0x80 byte
        mem_rdata = 64'h0000000080000000;
        do_req(1'b0, 3'b000, 64'h80000003, 64'd0);
        check("lb_rdata", r_rdata, 64'hFFFFFFFFFFFFFF80);
        check("lb_addr", m_addr, 64'h80000000);
        @(posedge clk); #1;
        do_req(1'b0, 3'b100, 64'h80000003, 64'd0);
        check("lbu_rdata", r_rdata, 64'h0000000000000080);
        @(posedge clk); #1;

        // SH into upper lanes
        do_req(1'b1, 3'b001, 64'h80000006, 64'h000000000000ABCD);
        check("sh_wstrb", {56'd0, m_wstrb}, 64'h00000000000000C0);
        check("sh_wdata_hi", {48'd0, m_wdata[63:48]}, 64'h000000000000ABCD);
        check("sh_we", {63'd0, m_we}, 64'd1);
        check("sh_rdata", r_rdata, 64'd0);
        check("sh_err", {63'd0, r_err}, 64'd0);
        @(posedge clk); #1;

        // Misaligned LW and illegal load funct3
        do_req(1'b0, 3'b010, 64'h80000002, 64'd0);
        check("lw_mis_lat", 64'(lat), 64'd1);
        check("lw_mis_err", {63'd0, r_err}, 64'd1);
        check("lw_mis_nomem", {63'd0, saw_mem}, 64'd0);
        @(posedge clk); #1;
        do_req(1'b0, 3'b111, 64'h80000010, 64'd0);
        check("ill_lat", 64'(lat), 64'd1);
        check("ill_err", {63'd0, r_err}, 64'd1);
        check("ill_nomem", {63'd0, saw_mem}, 64'd0);
        @(posedge clk); #1;

        // SD with 3 cycles of back-pressure; second request held meanwhile
        mem_req_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b011;
        req_addr = 64'h80000008; req_wdata = 64'h0102030405060708;
        @(posedge clk); #1;
        req_we = 1'b0; req_addr = 64'h80000100; req_wdata = 64'hDEAD;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_req_ready = 1'b1;
            @(negedge clk);
            check("sd_mvalid", {63'd0, mem_req_valid}, 64'd1);
            check("sd_addr", mem_addr, 64'h80000008);
            check("sd_wdata", mem_wdata, 64'h0102030405060708);
            check("sd_wstrb", {56'd0, mem_wstrb}, 64'hFF);
            check("sd_busy", {63'd0, busy}, 64'd1);
            check("sd_req_ready", {63'd0, req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("sd_wait_mvalid", {63'd0, mem_req_valid}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("sd_resp", {63'd0, resp_valid}, 64'd1);
        check("sd_rdata", resp_rdata, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("sd_idle", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;

        // Load nonzero data, then reset in WAIT
        mem_rdata = 64'h1122334455667788;
        do_req(1'b0, 3'b011, 64'h80000018, 64'd0);
        check("ld2_rdata", r_rdata, 64'h1122334455667788);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h80000020;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("wait_busy", {63'd0, busy}, 64'd1);
        check("wait_mvalid", {63'd0, mem_req_valid}, 64'd0);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_ready", {63'd0, req_ready}, 64'd1);
        check("arst_rdata", resp_rdata, 64'd0);
        check("arst_addr", mem_addr, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_resp_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("late_resp", {63'd0, resp_valid}, 64'd0);
            check("late_busy", {63'd0, busy}, 64'd0);
            @(posedge clk); #1;
        end
        do_req(1'b0, 3'b011, 64'h80000018, 64'd0);
        check("post_lat", 64'(lat), 64'd3);
        check("post_rdata", r_rdata, 64'h1122334455667788);
        check("post_err", {63'd0, r_err}, 64'd0);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
